// File: rtl/lsu_store_buffer.sv
// Speculative store buffer: holds stores until ROB commit, drains them in order, forwards to loads.
// Optional macro STORE_FWD_EN enables exact-match store-to-load forwarding; otherwise any overlap replays.
module lsu_store_buffer #(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int ROB_IDX_W = 4
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic                         in_st_valid,
    input  logic [ADDR_W-1:0]            in_st_addr,
    input  logic [DATA_W-1:0]            in_st_data,
    input  logic [ROB_IDX_W-1:0]         in_st_rob_index,
    output logic                         out_st_ready,
    input  logic                         in_ld_valid,
    input  logic [ADDR_W-1:0]            in_ld_addr,
    input  logic [ROB_IDX_W-1:0]         in_ld_rob_index,
    output logic                         out_ld_done,
    output logic [DATA_W-1:0]            out_ld_value,
    output logic [ROB_IDX_W-1:0]         out_ld_rob_index,
    output logic                         out_ld_replay,
    input  logic                         in_commit,
    input  logic [ROB_IDX_W-1:0]         in_commit_rob_index,
    input  logic                         in_flush,
    output logic                         out_mem_w_enable,
    output logic [ADDR_W-1:0]            out_mem_waddr,
    output logic [DATA_W-1:0]            out_mem_wval,
    output logic [ADDR_W-1:0]            out_mem_raddr,
    input  logic [DATA_W-1:0]            in_mem_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   out_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]    r_addr [DEPTH];
    logic [DATA_W-1:0]    r_data [DEPTH];
    logic [ROB_IDX_W-1:0] r_rob  [DEPTH];
    logic [DEPTH-1:0]     r_vld;
    logic [DEPTH-1:0]     r_cmt;
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_cptr;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     r_nunc;

    logic                 r_ld_done;
    logic [ADDR_W-1:0]    r_ld_addr;
    logic [ROB_IDX_W-1:0] r_ld_rob;
    logic                 r_ld_replay;
    logic                 r_ld_fwd;
    logic [DATA_W-1:0]    r_ld_fwd_data;

    logic                 w_alloc;
    logic                 w_commit;
    logic                 w_drain;
    logic [CNT_W-1:0]     w_flushed;
    logic [PTR_W-1:0]     w_cptr_nxt;
    logic                 w_fwd_hit;
    logic [DATA_W-1:0]    w_fwd_data;
    logic                 w_overlap;
    logic                 w_ld_replay;
    logic                 w_ld_fwd;
    logic [PTR_W-1:0]     w_idx;
    logic [ADDR_W-1:0]    w_diff;

    assign out_st_ready = (r_count < CNT_W'(DEPTH));
    assign w_alloc      = in_st_valid && out_st_ready && !in_flush;
    assign w_commit     = in_commit && (r_nunc != '0);
    assign w_drain      = r_vld[r_head] && r_cmt[r_head];
    assign w_cptr_nxt   = r_cptr + PTR_W'(w_commit);
    assign w_flushed    = in_flush ? (r_nunc - CNT_W'(w_commit)) : '0;

    // A reset cycle must not let a committed entry reach memory.
    assign out_mem_w_enable = w_drain && !in_rst;
    assign out_mem_waddr    = out_mem_w_enable ? r_addr[r_head] : '0;
    assign out_mem_wval     = out_mem_w_enable ? r_data[r_head] : '0;
    assign out_count        = r_count;

    // Valid entries are contiguous from head, so walking oldest-to-youngest lets the youngest match win.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_overlap  = 1'b0;
        w_idx      = '0;
        w_diff     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx  = r_head + PTR_W'(k);
            w_diff = (r_addr[w_idx] >= in_ld_addr) ? (r_addr[w_idx] - in_ld_addr)
                                                   : (in_ld_addr - r_addr[w_idx]);
            if (r_vld[w_idx]) begin
                if (r_addr[w_idx] == in_ld_addr) begin
                    w_fwd_hit  = 1'b1;
                    w_fwd_data = r_data[w_idx];
                end else if (w_diff < ADDR_W'(8)) begin
                    w_overlap = 1'b1;
                end
            end
        end
    end

`ifdef STORE_FWD_EN
    assign w_ld_fwd    = w_fwd_hit;
    assign w_ld_replay = w_overlap && !w_fwd_hit;
`else
    assign w_ld_fwd    = 1'b0;
    assign w_ld_replay = w_overlap || w_fwd_hit;
`endif

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_rob[i]  <= '0;
            end
            r_vld         <= '0;
            r_cmt         <= '0;
            r_head        <= '0;
            r_cptr        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_nunc        <= '0;
            r_ld_done     <= 1'b0;
            r_ld_addr     <= '0;
            r_ld_rob      <= '0;
            r_ld_replay   <= 1'b0;
            r_ld_fwd      <= 1'b0;
            r_ld_fwd_data <= '0;
        end else begin
            if (w_alloc) begin
                r_addr[r_tail] <= in_st_addr;
                r_data[r_tail] <= in_st_data;
                r_rob[r_tail]  <= in_st_rob_index;
                r_vld[r_tail]  <= 1'b1;
                r_cmt[r_tail]  <= 1'b0;
            end
            if (w_commit)
                r_cmt[r_cptr] <= 1'b1;
            if (w_drain) begin
                r_vld[r_head] <= 1'b0;
                r_cmt[r_head] <= 1'b0;
                r_head        <= r_head + PTR_W'(1);
            end
            if (in_flush) begin
                for (int i = 0; i < DEPTH; i++)
                    if (!r_cmt[i] && !(w_commit && (PTR_W'(i) == r_cptr)))
                        r_vld[i] <= 1'b0;
            end
            r_tail  <= in_flush ? w_cptr_nxt : (r_tail + PTR_W'(w_alloc));
            r_cptr  <= w_cptr_nxt;
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_drain) - w_flushed;
            r_nunc  <= in_flush ? '0 : (r_nunc + CNT_W'(w_alloc) - CNT_W'(w_commit));

            r_ld_done <= in_ld_valid;
            if (in_ld_valid) begin
                r_ld_addr     <= in_ld_addr;
                r_ld_rob      <= in_ld_rob_index;
                r_ld_replay   <= w_ld_replay;
                r_ld_fwd      <= w_ld_fwd;
                r_ld_fwd_data <= w_fwd_data;
            end
        end
    end

    assign out_ld_done      = r_ld_done;
    assign out_ld_replay    = r_ld_done && r_ld_replay;
    assign out_ld_rob_index = r_ld_rob;
    assign out_mem_raddr    = r_ld_addr;
    assign out_ld_value     = (r_ld_done && !r_ld_replay) ?
                              (r_ld_fwd ? r_ld_fwd_data : in_mem_rdata) : '0;

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            a_alloc_full: assert (!(in_st_valid && !out_st_ready));
            a_commit_none: assert (!(in_commit && (r_nunc == '0)));
            a_commit_rob: assert (!(w_commit && (in_commit_rob_index != r_rob[r_cptr])));
        end
    end
endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer: per-cycle vector table plus a reset-during-drain sequence.
module tb_lsu_store_buffer;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [63:0] MEMK = 64'hD000_0000_0000_0000;

    logic        in_clk, in_rst;
    logic        in_st_valid;
    logic [63:0] in_st_addr, in_st_data;
    logic [3:0]  in_st_rob_index;
    logic        out_st_ready;
    logic        in_ld_valid;
    logic [63:0] in_ld_addr;
    logic [3:0]  in_ld_rob_index;
    logic        out_ld_done;
    logic [63:0] out_ld_value;
    logic [3:0]  out_ld_rob_index;
    logic        out_ld_replay;
    logic        in_commit;
    logic [3:0]  in_commit_rob_index;
    logic        in_flush;
    logic        out_mem_w_enable;
    logic [63:0] out_mem_waddr, out_mem_wval, out_mem_raddr, in_mem_rdata;
    logic [2:0]  out_count;

    lsu_store_buffer dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_st_valid(in_st_valid), .in_st_addr(in_st_addr), .in_st_data(in_st_data),
        .in_st_rob_index(in_st_rob_index), .out_st_ready(out_st_ready),
        .in_ld_valid(in_ld_valid), .in_ld_addr(in_ld_addr), .in_ld_rob_index(in_ld_rob_index),
        .out_ld_done(out_ld_done), .out_ld_value(out_ld_value),
        .out_ld_rob_index(out_ld_rob_index), .out_ld_replay(out_ld_replay),
        .in_commit(in_commit), .in_commit_rob_index(in_commit_rob_index), .in_flush(in_flush),
        .out_mem_w_enable(out_mem_w_enable), .out_mem_waddr(out_mem_waddr),
        .out_mem_wval(out_mem_wval), .out_mem_raddr(out_mem_raddr),
        .in_mem_rdata(in_mem_rdata), .out_count(out_count)
    );

    // Memory image: every address reads back a distinct, recognisable word.
    assign in_mem_rdata = MEMK ^ out_mem_raddr;

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    int nwrites = 0;
    always @(posedge in_clk)
        if (out_mem_w_enable) nwrites++;

    typedef struct {
        logic        st_v;  logic [63:0] st_a; logic [63:0] st_d; logic [3:0] st_r;
        logic        ld_v;  logic [63:0] ld_a; logic [3:0]  ld_r;
        logic        cm;    logic [3:0]  cm_r; logic        fl;
        int          e_cnt; logic        e_rdy; logic       e_we;
        logic [63:0] e_wa;  logic [63:0] e_wv;
        logic        e_done; logic       e_rep; logic [63:0] e_val; logic [3:0] e_ldr;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad = 0;

    task automatic row(input logic st_v, input logic [63:0] st_a, input logic [63:0] st_d,
                       input logic [3:0] st_r, input logic ld_v, input logic [63:0] ld_a,
                       input logic [3:0] ld_r, input logic cm, input logic [3:0] cm_r,
                       input logic fl, input int e_cnt, input logic e_rdy, input logic e_we,
                       input logic [63:0] e_wa, input logic [63:0] e_wv, input logic e_done,
                       input logic e_rep, input logic [63:0] e_val, input logic [3:0] e_ldr);
        vec_t v;
        v.st_v = st_v; v.st_a = st_a; v.st_d = st_d; v.st_r = st_r;
        v.ld_v = ld_v; v.ld_a = ld_a; v.ld_r = ld_r;
        v.cm = cm; v.cm_r = cm_r; v.fl = fl;
        v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_we = e_we; v.e_wa = e_wa; v.e_wv = e_wv;
        v.e_done = e_done; v.e_rep = e_rep; v.e_val = e_val; v.e_ldr = e_ldr;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic drive_idle();
        in_st_valid = 1'b0; in_st_addr = '0; in_st_data = '0; in_st_rob_index = '0;
        in_ld_valid = 1'b0; in_ld_addr = '0; in_ld_rob_index = '0;
        in_commit = 1'b0; in_commit_rob_index = '0; in_flush = 1'b0;
    endtask

    initial begin
        drive_idle();
        in_rst = 1'b1;

        //  st_v addr    data  rob  ld_v addr    rob  cm rob fl | cnt rdy we waddr  wval  done rep   value          ldr
        row(0, 0,       0,    0,   0, 0,       0,   0, 0,  0,   0,  1,  0, 0,     0,    0,   0,    0,             0); // 0 reset state
        row(1, 'h10,    5,    2,   0, 0,       0,   0, 0,  0,   0,  1,  0, 0,     0,    0,   0,    0,             0); // 1
        row(0, 0,       0,    0,   0, 0,       0,   1, 2,  0,   1,  1,  0, 0,     0,    0,   0,    0,             0); // 2 commit
        row(0, 0,       0,    0,   0, 0,       0,   0, 0,  0,   1,  1,  1, 'h10,  5,    0,   0,    0,             0); // 3 drain
        row(0, 0,       0,    0,   0, 0,       0,   0, 0,  0,   0,  1,  0, 0,     0,    0,   0,    0,             0); // 4
        row(1, 'h20,    7,    3,   0, 0,       0,   0, 0,  0,   0,  1,  0, 0,     0,    0,   0,    0,             0); // 5
        row(0, 0,       0,    0,   1, 'h20,    9,   0, 0,  0,   1,  1,  0, 0,     0,    0,   0,    0,             0); // 6 load hits
        row(0, 0,       0,    0,   0, 0,       0,   0, 0,  0,   1,  1,  0, 0,     0,    1,   !FWD, 7,             9); // 7
        row(0, 0,       0,    0,   0, 0,       0,   0, 0,  1,   1,  1,  0, 0,     0,    0,   0,    0,             0); // 8 flush
        row(0, 0,       0,    0,   0, 0,       0,   0, 0,  0,   0,  1,  0, 0,     0,    0,   0,    0,             0); // 9
        row(1, 'h30,    1,    4,   0, 0,       0,   0, 0,  0,   0,  1,  0, 0,     0,    0,   0,    0,             0); // 10
        row(1, 'h30,    2,    5,   0, 0,       0,   0, 0,  0,   1,  1,  0, 0,     0,    0,   0,    0,             0); // 11
        row(0, 0,       0,    0,   1, 'h30,    1,   0, 0,  0,   2,  1,  0, 0,     0,    0,   0,    0,             0); // 12 youngest
        row(0, 0,       0,    0,   1, 'h34,    2,   0, 0,  0,   2,  1,  0, 0,     0,    1,   !FWD, 2,             1); // 13 partial
        row(0, 0,       0,    0,   1, 'h40,    3,   0, 0,  0,   2,  1,  0, 0,     0,    1,   1,    0,             2); // 14 no overlap
        row(0, 0,       0,    0,   0, 0,       0,   0, 0,  1,   2,  1,  0, 0,     0,    1,   0,    MEMK | 'h40,   3); // 15 flush
        row(0, 0,       0,    0,   0, 0,       0,   0, 0,  0,   0,  1,  0, 0,     0,    0,   0,    0,             0); // 16
        row(1, 'h100,   'hA,  6,   0, 0,       0,   0, 0,  0,   0,  1,  0, 0,     0,    0,   0,    0,             0); // 17 fill
        row(1, 'h108,   'hB,  7,   0, 0,       0,   0, 0,  0,   1,  1,  0, 0,     0,    0,   0,    0,             0); // 18
        row(1, 'h110,   'hC,  8,   0, 0,       0,   0, 0,  0,   2,  1,  0, 0,     0,    0,   0,    0,             0); // 19
        row(1, 'h118,   'hD,  9,   0, 0,       0,   0, 0,  0,   3,  1,  0, 0,     0,    0,   0,    0,             0); // 20
        row(0, 0,       0,    0,   0, 0,       0,   1, 6,  0,   4,  0,  0, 0,     0,    0,   0,    0,             0); // 21 full
        row(0, 0,       0,    0,   0, 0,       0,   0, 0,  0,   4,  0,  1, 'h100, 'hA,  0,   0,    0,             0); // 22 drain, still full
        row(0, 0,       0,    0,   0, 0,       0,   0, 0,  1,   3,  1,  0, 0,     0,    0,   0,    0,             0); // 23 ready again
        row(1, 'h200,   1,    10,  0, 0,       0,   0, 0,  0,   0,  1,  0, 0,     0,    0,   0,    0,             0); // 24
        row(1, 'h208,   2,    11,  0, 0,       0,   0, 0,  0,   1,  1,  0, 0,     0,    0,   0,    0,             0); // 25
        row(1, 'h210,   3,    12,  0, 0,       0,   0, 0,  0,   2,  1,  0, 0,     0,    0,   0,    0,             0); // 26
        row(0, 0,       0,    0,   0, 0,       0,   1, 10, 1,   3,  1,  0, 0,     0,    0,   0,    0,             0); // 27 commit+flush
        row(0, 0,       0,    0,   1, 'h208,   4,   0, 0,  0,   1,  1,  1, 'h200, 1,    0,   0,    0,             0); // 28
        row(0, 0,       0,    0,   0, 0,       0,   0, 0,  0,   0,  1,  0, 0,     0,    1,   0,    MEMK | 'h208,  4); // 29
        row(1, 'h300,   'h11, 13,  0, 0,       0,   0, 0,  0,   0,  1,  0, 0,     0,    0,   0,    0,             0); // 30
        row(1, 'h308,   'h22, 14,  0, 0,       0,   0, 0,  0,   1,  1,  0, 0,     0,    0,   0,    0,             0); // 31
        row(1, 'h310,   'h33, 15,  0, 0,       0,   1, 13, 1,   2,  1,  0, 0,     0,    0,   0,    0,             0); // 32 commit+flush+alloc
        row(0, 0,       0,    0,   0, 0,       0,   0, 0,  0,   1,  1,  1, 'h300, 'h11, 0,   0,    0,             0); // 33
        row(0, 0,       0,    0,   1, 'h310,   5,   0, 0,  0,   0,  1,  0, 0,     0,    0,   0,    0,             0); // 34 dropped store
        row(0, 0,       0,    0,   0, 0,       0,   0, 0,  0,   0,  1,  0, 0,     0,    1,   0,    MEMK | 'h310,  5); // 35

        repeat (3) @(negedge in_clk);
        in_rst = 1'b0;
        chk("raddr_rst", 0, out_mem_raddr, 64'h0);
        chk("ldval_rst", 0, out_ld_value, 64'h0);
        chk("waddr_rst", 0, out_mem_waddr, 64'h0);

        foreach (tbl[i]) begin
            chk("count", i, 64'(out_count), 64'(tbl[i].e_cnt));
            chk("st_ready", i, 64'(out_st_ready), 64'(tbl[i].e_rdy));
            chk("w_enable", i, 64'(out_mem_w_enable), 64'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                chk("waddr", i, out_mem_waddr, tbl[i].e_wa);
                chk("wval", i, out_mem_wval, tbl[i].e_wv);
            end
            chk("ld_done", i, 64'(out_ld_done), 64'(tbl[i].e_done));
            if (tbl[i].e_done) begin
                chk("ld_replay", i, 64'(out_ld_replay), 64'(tbl[i].e_rep));
                chk("ld_rob", i, 64'(out_ld_rob_index), 64'(tbl[i].e_ldr));
                if (!tbl[i].e_rep)
                    chk("ld_value", i, out_ld_value, tbl[i].e_val);
            end
            in_st_valid = tbl[i].st_v; in_st_addr = tbl[i].st_a;
            in_st_data = tbl[i].st_d; in_st_rob_index = tbl[i].st_r;
            in_ld_valid = tbl[i].ld_v; in_ld_addr = tbl[i].ld_a; in_ld_rob_index = tbl[i].ld_r;
            in_commit = tbl[i].cm; in_commit_rob_index = tbl[i].cm_r; in_flush = tbl[i].fl;
            @(negedge in_clk);
        end

        // Reset arriving in the drain cycle of a committed store.
        drive_idle();
        in_st_valid = 1'b1; in_st_addr = 64'h400; in_st_data = 64'h44; in_st_rob_index = 4'd1;
        @(negedge in_clk);
        drive_idle();
        in_commit = 1'b1; in_commit_rob_index = 4'd1;
        @(negedge in_clk);
        chk("pre_rst_we", 100, 64'(out_mem_w_enable), 64'h1);
        chk("pre_rst_cnt", 100, 64'(out_count), 64'h1);
        drive_idle();
        in_rst = 1'b1;
        #1;
        chk("rst_we", 101, 64'(out_mem_w_enable), 64'h0);
        @(negedge in_clk);
        in_rst = 1'b0;
        chk("post_rst_cnt", 102, 64'(out_count), 64'h0);
        chk("post_rst_we", 102, 64'(out_mem_w_enable), 64'h0);
        chk("post_rst_rdy", 102, 64'(out_st_ready), 64'h1);
        chk("post_rst_done", 102, 64'(out_ld_done), 64'h0);
        chk("post_rst_raddr", 102, out_mem_raddr, 64'h0);
        repeat (2) @(negedge in_clk);
        chk("post_rst_cnt2", 103, 64'(out_count), 64'h0);
        chk("write_total", 103, 64'(nwrites), 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_store_buffer.md
# lsu_store_buffer

Parametrised store buffer between the load-store reservation station and data memory. Stores are held speculatively until the ROB commits them, then drained in program order to memory. Loads check the buffer for store-to-load forwarding, and flushes on misprediction discard uncommitted stores, so mispredicted stores never reach memory. It replaces direct store writes in the functional-unit block.

## Interface
- DEPTH, 4: entries; power of two, ≥2
- DATA_W, 64: store/load data width (GPR size)
- ADDR_W, 64: address width
- ROB_IDX_W, 4: ROB index width
- in_clk  in  1  clock
- in_rst  in  1  synchronous, active-high reset
- in_st_valid  in  1  allocate store (STUR start)
- in_st_addr  in  ADDR_W  store byte address
- in_st_data  in  DATA_W  store value
- in_st_rob_index  in  ROB_IDX_W  store's ROB index
- out_st_ready  out  1  buffer not full
- in_ld_valid  in  1  load request (LDUR start)
- in_ld_addr  in  ADDR_W  load byte address
- in_ld_rob_index  in  ROB_IDX_W  load's ROB index
- out_ld_done  out  1  load result valid
- out_ld_value  out  DATA_W  load result
- out_ld_rob_index  out  ROB_IDX_W  load's ROB index
- out_ld_replay  out  1  load must be re-issued; value invalid
- in_commit  in  1  ROB commits oldest uncommitted store
- in_commit_rob_index  in  ROB_IDX_W  ROB index of committed store
- in_flush  in  1  mispredict; discard uncommitted stores
- out_mem_w_enable  out  1  memory write strobe
- out_mem_waddr  out  ADDR_W  write address
- out_mem_wval  out  DATA_W  write value
- out_mem_raddr  out  ADDR_W  read address (registered load address)
- in_mem_rdata  in  DATA_W  combinational memory read data for out_mem_raddr
- out_count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular FIFO with head (oldest), commit pointer (first uncommitted), and tail. Pointers wrap modulo DEPTH. Entry fields: addr, data, rob_index, committed.
- Allocate: when in_st_valid && out_st_ready, write the entry at tail and advance tail. in_st_valid with out_st_ready=0 is a protocol violation (assertion).
- Commit: in_commit marks the entry at the commit pointer committed and advances that pointer. Assert that in_commit_rob_index equals the entry's rob_index and that at least one uncommitted entry exists.
- Drain: if the head entry is committed, out_mem_w_enable=1 with out_mem_waddr/out_mem_wval = head.addr/head.data. At the clock edge, memory writes and head advances. Drains one entry per cycle.
- Flush: tail := commit pointer (after any same-cycle commit). Committed entries are kept and keep draining. Same-cycle allocate is dropped.
- Load: the request registers at the edge. In the next cycle out_ld_done=1 and out_mem_raddr = the registered address.
  - Matching is against buffer contents in the request cycle, including an entry draining that cycle. A store allocated in the same cycle is not considered.
  - Youngest entry with addr == load addr: forward its data.
  - Otherwise, any entry with |addr − load addr| < 8 (partial overlap): out_ld_replay=1.
  - Otherwise, out_ld_value = in_mem_rdata.
- A flush in the result cycle does not suppress out_ld_done; the ROB discards the result.
- Reset: all pointers and counts 0, all valid bits cleared. Outputs: out_st_ready=1; out_count, out_ld_done, out_ld_replay, out_mem_w_enable = 0; data and address outputs 0.

## Timing
- out_st_ready = (count < DEPTH), from registered state only; a same-cycle drain does not raise it.
- A store is allocated at edge t and is forwardable to loads requested from cycle t+1.
- A commit at edge t makes the earliest write cycle t+1 (out_mem_w_enable is combinational from state).
- Load latency is 1 cycle; back-to-back loads are accepted every cycle.
- Count update per edge: +alloc − drain − flushed-uncommitted.
- in_rst mid-operation discards all entries, including committed-but-undrained ones, with no memory write.

## Configuration
- STORE_FWD_EN defined: exact-match forwarding as above.
- STORE_FWD_EN undefined: any overlap, including an exact match, sets out_ld_replay=1. There is no forwarding path, and out_ld_value comes only from in_mem_rdata.

## Test plan
- Store addr 0x10 data 5 (rob 2), commit rob 2: out_mem_w_enable=1 with waddr 0x10, wval 5 exactly one cycle after commit; out_count returns to 0.
- Store 0x20←7 (uncommitted), then load 0x20: with STORE_FWD_EN, out_ld_value=7 and replay=0; without it, replay=1. Memory is not written.
- Stores 0x30←1 then 0x30←2, load 0x30: value 2 (youngest wins). Load 0x34: replay=1.
- Fill 4 stores: out_st_ready=0. Commit one: the drain cycle writes memory, and out_st_ready=1 the cycle after.
- 3 stores, commit the first, flush: out_count=1, only the committed store is written, and a load of a flushed store's address reads memory.
- Commit and flush in the same cycle with an allocate: the commit is kept, the allocate is dropped, and count is correct. Reset mid-drain: no write, out_count=0.
